mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Parametrised multicycle control sequencer for the RV32I non-pipelined core.
- Replaces the fixed one-cycle load bubble and one-cycle redirect hold with an explicit FSM over valid/ready IMEM and DMEM handshakes of arbitrary latency.
- Owns PC, the executing instruction register, write-enable timing, the retire counter and fault/halt reporting.
- Sits between the memories and the existing ID/EX/regfile datapath; the decode and EX outputs feed back into it.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0013, value of instr while no valid instruction is held.
- WAIT_LIMIT, 0, maximum cycles spent in a WAIT state before a fault; 0 disables the timeout.
- CNT_W, 64, width of the instret counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  fetch request accepted.
- imem_addr  out  XLEN  fetch address, equal to pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction.
- dmem_req_valid  out  1  data request.
- dmem_req_ready  in  1  data request accepted.
- dmem_req_we  out  1  1 = store, 0 = load.
- dmem_rsp_valid  in  1  load data valid, or store acknowledge.
- dec_is_load  in  1  decoded from instr.
- dec_is_store  in  1  decoded from instr.
- dec_reg_write  in  1  decoded from instr.
- dec_halt  in  1  ecall or ebreak.
- ex_redirect  in  1  taken branch, jal or jalr.
- ex_target  in  XLEN  redirect target.
- pc  out  XLEN  fetch PC.
- pc_exec  out  XLEN  PC aligned with instr.
- instr  out  32  instruction being executed.
- ex_valid  out  1  high for exactly the EXEC cycle.
- rf_wen  out  1  register file write enable.
- mem_to_reg  out  1  selects DMEM response data as write-back data.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- halted  out  1  FSM is in HALT.
- fault_cause  out  2  0 none, 1 fetch timeout, 2 memory timeout, 3 misaligned target.

Behaviour:
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, HALT.
- Reset (asynchronous): state = FETCH_REQ, pc = RESET_PC, pc_exec = RESET_PC, instr = NOP, instret = 0, fault_cause = 0, wait counter = 0.
- All outputs not listed above are 0 during reset. Reset mid-transaction abandons it; any later rsp_valid is ignored until the FSM requests again.
- FETCH_REQ: imem_req_valid = 1, imem_addr = pc, both held stable until imem_req_ready. On the ready cycle, go to FETCH_WAIT.
- FETCH_WAIT: on imem_rsp_valid, instr <= imem_rsp_data, pc_exec <= pc, go to EXEC. A response is never consumed in the cycle its request is accepted.
- EXEC: ex_valid = 1; instr is held. Priority order:
  1. dec_halt -> HALT, no retire.
  2. ex_redirect with ex_target[1:0] != 0 -> fault_cause = 3, HALT.
  3. dec_is_load or dec_is_store -> MEM_REQ, rf_wen = 0.
  4. Otherwise: rf_wen = dec_reg_write; pc <= ex_redirect ? ex_target : pc + 4 (modulo 2^XLEN); retire = 1; go to FETCH_REQ.
- MEM_REQ: dmem_req_valid = 1, dmem_req_we = dec_is_store, held until dmem_req_ready, then go to MEM_WAIT. This issues exactly one request per memory instruction.
- MEM_WAIT: on dmem_rsp_valid:
  - Load: rf_wen = 1 and mem_to_reg = 1 in that same cycle.
  - Store: rf_wen = 0.
  - Both: pc <= pc + 4, retire = 1, go to FETCH_REQ.
- instr and pc_exec stay stable from EXEC through MEM_WAIT, so the decode and EX outputs remain valid.
- Timeout (WAIT_LIMIT > 0): the counter clears on entry to a WAIT state and increments each cycle without a response. When it reaches WAIT_LIMIT without a response, go to HALT with fault_cause = 1 (from FETCH_WAIT) or 2 (from MEM_WAIT). A response arriving in the same cycle the limit is reached wins.
- rsp_valid inputs outside their WAIT state are ignored.
- HALT: absorbing until reset. No requests, rf_wen = 0, halted = 1; pc and instret are frozen.
- instret increments by 1 on every retire and wraps at 2^CNT_W.
- rf_wen is never asserted outside EXEC or MEM_WAIT.

Test Plan:
- Reset, then a zero-latency IMEM (ready = 1, rsp one cycle later) supplying addi x1, x0, 5 -> imem_addr = 0; ex_valid in cycle 3; rf_wen = 1; retire; next fetch at 4; instret = 1.
- Beq taken with ex_target = 0x40 -> next imem_addr = 0x40, no fetch of 0x4, rf_wen = 0.
- Beq with ex_target = 0x42 -> fault_cause = 3, halted = 1, instret unchanged.
- Lw with dmem_req_ready delayed 3 cycles and response 2 cycles later -> dmem_req_valid high for exactly 4 cycles, a single request, rf_wen and mem_to_reg high for exactly 1 cycle at the response.
- Sw -> dmem_req_we = 1, no rf_wen, retire on acknowledge.
- WAIT_LIMIT = 4 with IMEM never responding -> fault_cause = 1 after 4 FETCH_WAIT cycles.
- A response in exactly the limit cycle -> completes normally, no fault.
- Reset asserted during MEM_WAIT, then dmem_rsp_valid -> response ignored, pc = RESET_PC, instr = NOP.
- Ebreak -> halted = 1, no further imem_req_valid.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer for the RV32I non-pipelined core.
// Drives valid/ready handshakes to IMEM and DMEM of arbitrary latency, owns
// the fetch PC, the executing instruction register, register-file write
// timing, the retired-instruction counter and fault/halt reporting.
module mc_sequencer #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0]     NOP        = 32'h0000_0013,
  parameter int unsigned     WAIT_LIMIT = 0,
  parameter int unsigned     CNT_W      = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_req_we,
  input  logic             dmem_rsp_valid,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_reg_write,
  input  logic             dec_halt,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_exec,
  output logic [31:0]      instr,
  output logic             ex_valid,
  output logic             rf_wen,
  output logic             mem_to_reg,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       fault_cause
);

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  localparam logic [1:0] FAULT_FETCH_TO  = 2'd1;
  localparam logic [1:0] FAULT_MEM_TO    = 2'd2;
  localparam logic [1:0] FAULT_MISALIGN  = 2'd3;
  localparam logic [31:0] LIMIT_LAST     = 32'(WAIT_LIMIT - 1);

  state_t      state;
  logic [31:0] wait_cnt;

  logic exec_misalign;
  logic exec_mem;
  logic exec_done;
  logic mem_done;
  logic limit_hit;

  // Resolve the EXEC priority chain and MEM_WAIT completion for this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    exec_misalign = 1'b0;
    exec_mem      = 1'b0;
    exec_done     = 1'b0;
    mem_done      = 1'b0;
    if (state == S_EXEC && !dec_halt) begin
      if (ex_redirect && (ex_target[1:0] != 2'b00)) begin
        exec_misalign = 1'b1;
      end else if (dec_is_load || dec_is_store) begin
        exec_mem = 1'b1;
      end else begin
        exec_done = 1'b1;
      end
    end
    if (state == S_MEM_WAIT && dmem_rsp_valid) begin
      mem_done = 1'b1;
    end
  end

  // A response arriving in the limit cycle takes precedence over the timeout.
  assign limit_hit = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT_LAST);

  // Handshake requests are held by state alone; nothing is requested in reset.
  assign imem_req_valid = (state == S_FETCH_REQ) && !rst;
  assign imem_addr      = pc;
  assign dmem_req_valid = (state == S_MEM_REQ);
  assign dmem_req_we    = (state == S_MEM_REQ) && dec_is_store;
  assign ex_valid       = (state == S_EXEC);
  assign halted         = (state == S_HALT);

  // Write-back and retire are same-cycle decisions on decode/response inputs.
  assign retire     = exec_done || mem_done;
  assign rf_wen     = (exec_done && dec_reg_write) || (mem_done && dec_is_load);
  assign mem_to_reg = mem_done && dec_is_load;

  // Sequencer state, PC, instruction register, counters and fault cause.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= S_FETCH_REQ;
      pc          <= RESET_PC;
      pc_exec     <= RESET_PC;
      instr       <= NOP;
      instret     <= '0;
      fault_cause <= 2'd0;
      wait_cnt    <= '0;
    end else begin
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
      case (state)
        S_FETCH_REQ: begin
          if (imem_req_ready) begin
            wait_cnt <= '0;
            state    <= S_FETCH_WAIT;
          end
        end
        S_FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            instr   <= imem_rsp_data;
            pc_exec <= pc;
            state   <= S_EXEC;
          end else if (limit_hit) begin
            fault_cause <= FAULT_FETCH_TO;
            state       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_EXEC: begin
          if (dec_halt) begin
            state <= S_HALT;
          end else if (exec_misalign) begin
            fault_cause <= FAULT_MISALIGN;
            state       <= S_HALT;
          end else if (exec_mem) begin
            state <= S_MEM_REQ;
          end else begin
            pc    <= ex_redirect ? ex_target : pc + XLEN'(4);
            state <= S_FETCH_REQ;
          end
        end
        S_MEM_REQ: begin
          if (dmem_req_ready) begin
            wait_cnt <= '0;
            state    <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_rsp_valid) begin
            pc    <= pc + XLEN'(4);
            state <= S_FETCH_REQ;
          end else if (limit_hit) begin
            fault_cause <= FAULT_MEM_TO;
            state       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: a table of single-cycle instructions
// followed by hand-written sequences for memory, timeout, reset and halt cases.
module tb_mc_sequencer;

  localparam logic [31:0] NOP_W   = 32'h0000_0013;
  localparam logic [31:0] ADDI    = 32'h0050_0093;
  localparam logic [31:0] ADD     = 32'h0010_80b3;
  localparam logic [31:0] BEQ     = 32'h0200_0c63;
  localparam logic [31:0] JAL     = 32'h0c00_00ef;
  localparam logic [31:0] LUI     = 32'h0001_22b7;
  localparam logic [31:0] LW      = 32'h0000_a183;
  localparam logic [31:0] SW      = 32'h0020_a023;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_rsp_valid;
  logic        dec_is_load, dec_is_store, dec_reg_write, dec_halt;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] pc, pc_exec, instr;
  logic        ex_valid, rf_wen, mem_to_reg, retire, halted;
  logic [63:0] instret;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mc_sequencer #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .NOP(NOP_W), .WAIT_LIMIT(4), .CNT_W(64)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_rsp_valid(dmem_rsp_valid),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_reg_write(dec_reg_write), .dec_halt(dec_halt),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .pc(pc), .pc_exec(pc_exec), .instr(instr), .ex_valid(ex_valid),
    .rf_wen(rf_wen), .mem_to_reg(mem_to_reg), .retire(retire),
    .instret(instret), .halted(halted), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the ID stage: decode control bits from the held instruction.
  always_comb begin
    logic [6:0] opc;
    opc           = instr[6:0];
    dec_is_load   = (opc == 7'b0000011);
    dec_is_store  = (opc == 7'b0100011);
    dec_halt      = (opc == 7'b1110011);
    dec_reg_write = (opc inside {7'b0010011, 7'b0110011, 7'b0000011, 7'b1101111,
                                 7'b1100111, 7'b0110111, 7'b0010111});
  end

  typedef struct {
    logic [31:0] word;
    logic        redir;
    logic [31:0] target;
    logic        exp_wen;
    logic [31:0] exp_pc_exec;
    logic [31:0] exp_next;
    logic [63:0] exp_instret;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    ex_redirect = 1'b0; ex_target = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs one fetch from FETCH_REQ, inserting wait_cycles empty FETCH_WAIT cycles.
  task automatic do_fetch(input logic [31:0] word, input int wait_cycles);
    imem_req_ready = 1'b1;
    #1;
    check("fetch_req_valid", imem_req_valid, 1'b1);
    tick();
    imem_req_ready = 1'b0;
    for (int k = 0; k < wait_cycles; k++) tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int req_cnt;
    vecs[0] = '{ADDI, 1'b0, 32'h0,   1'b1, 32'h0,   32'h4,   64'd1};
    vecs[1] = '{ADD,  1'b0, 32'h0,   1'b1, 32'h4,   32'h8,   64'd2};
    vecs[2] = '{BEQ,  1'b1, 32'h40,  1'b0, 32'h8,   32'h40,  64'd3};
    vecs[3] = '{JAL,  1'b1, 32'h100, 1'b1, 32'h40,  32'h100, 64'd4};
    vecs[4] = '{LUI,  1'b0, 32'h0,   1'b1, 32'h100, 32'h104, 64'd5};

    // Reset values
    do_reset();
    base = cyc;
    check("rst_pc", pc, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr", instr, NOP_W);
    check("rst_instret", instret, 64'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_rf_wen", rf_wen, 1'b0);

    // Table of single-cycle instructions with a zero-latency IMEM
    for (int i = 0; i < 5; i++) begin
      do_fetch(vecs[i].word, 0);
      if (i == 0) check("exec_cycle", 64'(cyc - base + 1), 64'd3);
      ex_redirect = vecs[i].redir;
      ex_target   = vecs[i].target;
      #1;
      check("tbl_ex_valid", ex_valid, 1'b1);
      check("tbl_instr", instr, vecs[i].word);
      check("tbl_pc_exec", pc_exec, vecs[i].exp_pc_exec);
      check("tbl_rf_wen", rf_wen, vecs[i].exp_wen);
      check("tbl_retire", retire, 1'b1);
      check("tbl_mem_to_reg", mem_to_reg, 1'b0);
      tick();
      ex_redirect = 1'b0;
      #1;
      check("tbl_next_addr", imem_addr, vecs[i].exp_next);
      check("tbl_instret", instret, vecs[i].exp_instret);
      check("tbl_idle_wen", rf_wen, 1'b0);
    end

    // Load: request ready after 3 stall cycles, response 2 cycles later
    do_fetch(LW, 0);
    #1;
    check("lw_exec_wen", rf_wen, 1'b0);
    check("lw_exec_retire", retire, 1'b0);
    tick();
    req_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      dmem_req_ready = (k == 3);
      #1;
      if (dmem_req_valid) req_cnt++;
      check("lw_req_we", dmem_req_we, 1'b0);
      tick();
    end
    dmem_req_ready = 1'b0;
    check("lw_req_cycles", 64'(req_cnt), 64'd4);
    check("lw_wait_wen", rf_wen, 1'b0);
    check("lw_single_req", dmem_req_valid, 1'b0);
    tick();
    dmem_rsp_valid = 1'b1;
    #1;
    check("lw_rsp_wen", rf_wen, 1'b1);
    check("lw_rsp_m2r", mem_to_reg, 1'b1);
    check("lw_rsp_retire", retire, 1'b1);
    check("lw_instr_stable", instr, LW);
    check("lw_pc_exec_stable", pc_exec, 32'h104);
    tick();
    dmem_rsp_valid = 1'b0;
    #1;
    check("lw_after_wen", rf_wen, 1'b0);
    check("lw_after_m2r", mem_to_reg, 1'b0);
    check("lw_next_addr", imem_addr, 32'h108);
    check("lw_instret", instret, 64'd6);

    // Store: immediate ready and acknowledge
    do_fetch(SW, 0);
    tick();
    dmem_req_ready = 1'b1;
    #1;
    check("sw_req_valid", dmem_req_valid, 1'b1);
    check("sw_req_we", dmem_req_we, 1'b1);
    tick();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    #1;
    check("sw_ack_wen", rf_wen, 1'b0);
    check("sw_ack_retire", retire, 1'b1);
    tick();
    dmem_rsp_valid = 1'b0;
    check("sw_instret", instret, 64'd7);
    check("sw_next_addr", imem_addr, 32'h10c);

    // IMEM response in exactly the limit cycle completes normally
    do_fetch(ADDI, 3);
    #1;
    check("lim_ex_valid", ex_valid, 1'b1);
    check("lim_halted", halted, 1'b0);
    check("lim_fault", fault_cause, 2'd0);
    tick();
    check("lim_instret", instret, 64'd8);
    check("lim_next_addr", imem_addr, 32'h110);

    // Reset during MEM_WAIT; a late response must be ignored
    do_fetch(LW, 0);
    tick();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_pc", pc, 32'h0);
    check("mrst_instr", instr, NOP_W);
    check("mrst_instret", instret, 64'd0);
    check("mrst_imem_req", imem_req_valid, 1'b0);
    check("mrst_dmem_req", dmem_req_valid, 1'b0);
    tick();
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    #1;
    check("mrst_late_wen", rf_wen, 1'b0);
    check("mrst_late_retire", retire, 1'b0);
    check("mrst_fetch_req", imem_req_valid, 1'b1);
    tick();
    dmem_rsp_valid = 1'b0;
    check("mrst_instret_after", instret, 64'd0);
    check("mrst_still_fetch", imem_req_valid, 1'b1);

    // Misaligned redirect target faults without retiring
    do_fetch(BEQ, 0);
    ex_redirect = 1'b1;
    ex_target   = 32'h42;
    #1;
    check("mis_retire", retire, 1'b0);
    check("mis_wen", rf_wen, 1'b0);
    tick();
    ex_redirect = 1'b0;
    check("mis_halted", halted, 1'b1);
    check("mis_fault", fault_cause, 2'd3);
    check("mis_instret", instret, 64'd0);
    check("mis_pc", pc, 32'h0);

    // IMEM never responds: fetch timeout after 4 FETCH_WAIT cycles
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("to_not_yet", halted, 1'b0);
      tick();
    end
    check("to_halted", halted, 1'b1);
    check("to_fault", fault_cause, 2'd1);

    // Ebreak halts with no fault and no further fetches
    do_reset();
    do_fetch(ADDI, 0);
    tick();
    do_fetch(EBREAK, 0);
    #1;
    check("ebk_ex_valid", ex_valid, 1'b1);
    check("ebk_retire", retire, 1'b0);
    tick();
    check("ebk_halted", halted, 1'b1);
    check("ebk_fault", fault_cause, 2'd0);
    check("ebk_instret", instret, 64'd1);
    imem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ebk_no_fetch", imem_req_valid, 1'b0);
      check("ebk_pc_frozen", pc, 32'h4);
    end
    imem_req_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
